// File: rtl/quadrilatero_dot_sequencer.sv
// quadrilatero_dot_sequencer
// Computes a dot product on a single FP32 MAC lane. It issues one operand pair at a time
// together with the running accumulator, then collects the MAC result as the next
// accumulator. The final sum is presented on a valid/ready result port.
// Values pass through bit-exact; no arithmetic is done here.

module quadrilatero_dot_sequencer #(
   parameter int LEN_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,

   input  logic             start_i,
   input  logic [LEN_W-1:0] len_i,
   input  logic [31:0]      init_acc_i,
   output logic             busy_o,

   input  logic             op_valid_i,
   input  logic [31:0]      op_data_i,
   input  logic [31:0]      op_weight_i,
   output logic             op_ready_o,

   output logic             mac_valid_o,
   output logic [31:0]      mac_data_o,
   output logic [31:0]      mac_weight_o,
   output logic [31:0]      mac_acc_o,
   input  logic             mac_finished_i,
   input  logic [31:0]      mac_acc_i,

   output logic             res_valid_o,
   output logic [31:0]      res_o,
   input  logic             res_ready_i
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [LEN_W-1:0] cnt;
   logic [LEN_W-1:0] cnt_next;
   logic [31:0]      acc;
   logic [31:0]      acc_next;
   logic             op_fire;

   assign op_fire = (state == ISSUE) && op_valid_i;

   // Next-state and datapath decisions; only one MAC operation can be in flight at a time
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      acc_next   = acc;
      unique case (state)
         IDLE: begin
            if (start_i) begin
               acc_next   = init_acc_i;
               cnt_next   = len_i;
               state_next = (len_i == '0) ? DONE : ISSUE;
            end
         end
         ISSUE: begin
            if (op_valid_i) begin
               state_next = WAIT;
            end
         end
         WAIT: begin
            if (mac_finished_i) begin
               acc_next   = mac_acc_i;
               cnt_next   = cnt - LEN_W'(1);
               state_next = (cnt == LEN_W'(1)) ? DONE : ISSUE;
            end
         end
         DONE: begin
            if (res_ready_i) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State, length counter and running accumulator registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state <= IDLE;
         cnt   <= '0;
         acc   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         acc   <= acc_next;
      end
   end

   // MAC operand registers, loaded on the operand handshake, with a one-cycle issue pulse
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mac_valid_o  <= 1'b0;
         mac_data_o   <= '0;
         mac_weight_o <= '0;
         mac_acc_o    <= '0;
      end else begin
         mac_valid_o <= op_fire;
         if (op_fire) begin
            mac_data_o   <= op_data_i;
            mac_weight_o <= op_weight_i;
            mac_acc_o    <= acc;
         end
      end
   end

   // Status outputs decoded from the state; the result is the accumulator, which is frozen in DONE
   always_comb begin
      busy_o      = (state != IDLE);
      op_ready_o  = (state == ISSUE);
      res_valid_o = (state == DONE);
      res_o       = acc;
   end

endmodule
